// File: rtl/nios_system_hex_pkg.sv
// Shared constants for the hex bank: register map, DIGIT field positions, hex-to-segment table.
// Segment bit 0 = a ... bit 6 = g, 1 = lit (polarity applied at the pins).
package nios_system_hex_pkg;

  localparam logic [3:0] ADDR_CTRL   = 4'd8;
  localparam logic [3:0] ADDR_BLINK  = 4'd9;
  localparam logic [3:0] ADDR_STATUS = 4'd11;

  localparam int         DIGIT_RAW    = 7;
  localparam logic [7:0] DIGIT_RESET  = 8'h80;
  localparam int         CTRL_EN      = 0;
  localparam int         CTRL_RESTART = 1;

  // Entry 0 is the rightmost element of the concatenation.
  localparam logic [15:0][6:0] HEX_SEG = {
    7'h71, 7'h79, 7'h5E, 7'h39, 7'h7C, 7'h77, 7'h6F, 7'h7F,
    7'h07, 7'h7D, 7'h6D, 7'h66, 7'h4F, 7'h5B, 7'h06, 7'h3F
  };

  function automatic logic [6:0] hex_decode(input logic [3:0] nib);
    return HEX_SEG[nib];
  endfunction

endpackage

// File: rtl/nios_system_hex_blink_div.sv
// Blink prescaler: counts 0..BLINK_DIV-1 and toggles phase on each wrap.
// Restart clears counter and phase in the same cycle and overrides a coincident wrap.
module nios_system_hex_blink_div #(
  parameter int BLINK_DIV = 25000000
) (
  input  logic clk,
  input  logic reset_n,
  input  logic restart,
  output logic phase
);

  localparam int            CW   = $clog2(BLINK_DIV);
  localparam logic [CW-1:0] LAST = CW'(BLINK_DIV - 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt   <= '0;
      phase <= 1'b0;
    end else if (restart) begin
      cnt   <= '0;
      phase <= 1'b0;
    end else if (cnt == LAST) begin
      cnt   <= '0;
      phase <= ~phase;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/nios_system_hex_bank.sv
// Avalon-MM seven-segment bank: per-digit raw/hex registers, global enable, optional blink
// (HEX_BANK_BLINK_EN). Zero-wait-state reads; pins registered, one cycle after the write edge.
module nios_system_hex_bank
  import nios_system_hex_pkg::*;
#(
  parameter int NUM_DIGITS = 6,
  parameter int ACTIVE_LOW = 1,
  parameter int BLINK_DIV  = 25000000
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic [3:0]              address,
  input  logic                    chipselect,
  input  logic                    write_n,
  input  logic [31:0]             writedata,
  output logic [31:0]             readdata,
  output logic [7*NUM_DIGITS-1:0] out_port
);

  localparam logic [7*NUM_DIGITS-1:0] SEG_OFF = {7*NUM_DIGITS{ACTIVE_LOW != 0}};

  logic [7:0]              digit [NUM_DIGITS];
  logic                    en;
  logic                    wr;
  logic                    phase;
  logic [NUM_DIGITS-1:0]   blink;
  logic [7*NUM_DIGITS-1:0] seg_next;
  logic                    unused_wdata;

  assign wr           = chipselect & ~write_n;
  assign unused_wdata = ^writedata[31:8];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < NUM_DIGITS; i++) digit[i] <= DIGIT_RESET;
      en <= 1'b1;
    end else if (wr) begin
      for (int i = 0; i < NUM_DIGITS; i++)
        if (address == 4'(i)) digit[i] <= writedata[7:0];
      if (address == ADDR_CTRL) en <= writedata[CTRL_EN];
    end
  end

`ifdef HEX_BANK_BLINK_EN
  logic restart;
  assign restart = wr && (address == ADDR_CTRL) && writedata[CTRL_RESTART];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)                           blink <= '0;
    else if (wr && address == ADDR_BLINK)   blink <= writedata[NUM_DIGITS-1:0];
  end

  nios_system_hex_blink_div #(.BLINK_DIV(BLINK_DIV)) u_blink_div (
    .clk     (clk),
    .reset_n (reset_n),
    .restart (restart),
    .phase   (phase)
  );
`else
  logic unused_cfg;
  assign blink      = '0;
  assign phase      = 1'b0;
  assign unused_cfg = (BLINK_DIV > 1);
`endif

  always_comb begin
    readdata = '0;
    for (int i = 0; i < NUM_DIGITS; i++)
      if (address == 4'(i)) readdata[7:0] = digit[i];
    if (address == ADDR_CTRL)   readdata[0] = en;
    if (address == ADDR_BLINK)  readdata[NUM_DIGITS-1:0] = blink;
    if (address == ADDR_STATUS) readdata[0] = phase;
  end

  // Logical segments (1 = lit) first; pin polarity applied last.
  always_comb begin
    seg_next = '0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      seg_next[7*i +: 7] = digit[i][DIGIT_RAW] ? digit[i][6:0] : hex_decode(digit[i][3:0]);
      if (!en || (blink[i] && phase)) seg_next[7*i +: 7] = '0;
    end
    if (ACTIVE_LOW != 0) seg_next = ~seg_next;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) out_port <= SEG_OFF;
    else          out_port <= seg_next;
  end

endmodule

// File: tb/tb_nios_system_hex_bank.sv
// Bench for nios_system_hex_bank (NUM_DIGITS=6, ACTIVE_LOW=1, BLINK_DIV=4); blink expectations follow HEX_BANK_BLINK_EN.
module tb_nios_system_hex_bank;

  localparam int ND = 6;
  localparam int D  = 4;
  localparam int W  = 7 * ND;
`ifdef HEX_BANK_BLINK_EN
  localparam bit BLK = 1'b1;
`else
  localparam bit BLK = 1'b0;
`endif

  logic          clk;
  logic          reset_n;
  logic [3:0]    address;
  logic          chipselect;
  logic          write_n;
  logic [31:0]   writedata;
  logic [31:0]   readdata;
  logic [W-1:0]  out_port;

  nios_system_hex_bank #(.NUM_DIGITS(ND), .ACTIVE_LOW(1), .BLINK_DIV(D)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .address    (address),
    .chipselect (chipselect),
    .write_n    (write_n),
    .writedata  (writedata),
    .readdata   (readdata),
    .out_port   (out_port)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: register contents plus "edges since reset/restart" for the blink phase.
  logic [6:0]   tbl [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                             7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};
  logic [7:0]   m_dig [ND];
  logic         m_en;
  logic [ND-1:0] m_blink;
  int           m_n;
  logic [W-1:0] m_out;
  bit           cmp_on = 1'b0;

  function automatic bit m_phase();
    return BLK && (((m_n / D) % 2) == 1);
  endfunction

  function automatic logic [W-1:0] m_pins();
    logic [W-1:0] p;
    p = '0;
    for (int i = 0; i < ND; i++) begin
      logic [6:0] s;
      s = m_dig[i][7] ? m_dig[i][6:0] : tbl[m_dig[i][3:0]];
      if (!m_en || (m_blink[i] && m_phase())) s = 7'h00;
      p[7*i +: 7] = s;
    end
    return ~p;
  endfunction

  function automatic logic [31:0] m_read(input logic [3:0] a);
    int ai;
    ai = a;
    if (ai < ND)  return {24'h0, m_dig[ai]};
    if (ai == 8)  return {31'h0, m_en};
    if (ai == 9)  return {26'h0, m_blink};
    if (ai == 11) return {31'h0, m_phase()};
    return 32'h0;
  endfunction

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < ND; i++) m_dig[i] = 8'h80;
      m_en    = 1'b1;
      m_blink = '0;
      m_n     = 0;
      m_out   = '1;
    end else begin
      bit rs;
      int ai;
      rs    = 1'b0;
      m_out = m_pins();
      if (chipselect && !write_n) begin
        ai = address;
        if (ai < ND) m_dig[ai] = writedata[7:0];
        if (ai == 8) begin
          m_en = writedata[0];
          rs   = BLK && writedata[1];
        end
        if (ai == 9 && BLK) m_blink = writedata[ND-1:0];
      end
      m_n = rs ? 0 : m_n + 1;
    end
  end

  always @(negedge clk) begin
    if (cmp_on) begin
      check("model_out_port", {22'h0, out_port}, {22'h0, m_out});
      check("model_readdata", {32'h0, readdata}, {32'h0, m_read(address)});
    end
  end

  task automatic wr(input logic [3:0] a, input logic [31:0] d);
    @(posedge clk); #1;
    chipselect = 1'b1; write_n = 1'b0; address = a; writedata = d;
    @(posedge clk); #1;
    chipselect = 1'b0; write_n = 1'b1;
  endtask

  logic [W-1:0] all_off = '1;
  logic [11:0]  st_exp  = 12'b1000_0111_1000;
  logic [11:0]  of_exp  = 12'b0000_1111_0000;

  initial begin
    reset_n = 1'b0; chipselect = 1'b0; write_n = 1'b1; address = 4'd0; writedata = '0;
    repeat (3) @(posedge clk);
    #1 reset_n = 1'b1;
    cmp_on = 1'b1;

    @(negedge clk);
    check("rst_out_port", {22'h0, out_port}, {22'h0, all_off});
    address = 4'd0; #1 check("rst_digit0", {32'h0, readdata}, 64'h80);
    address = 4'd8; #1 check("rst_ctrl", {32'h0, readdata}, 64'h1);

    wr(4'd2, 32'h0000_0005);
    check("latency_hold", {57'h0, out_port[20:14]}, 64'h7F);
    @(posedge clk); #1;
    check("digit2_hex5", {57'h0, out_port[20:14]}, 64'h12);
    address = 4'd2; #1 check("read_digit2", {32'h0, readdata}, 64'h05);

    wr(4'd0, 32'hFFFF_FFC9);
    @(posedge clk); #1;
    check("digit0_raw49", {57'h0, out_port[6:0]}, 64'h36);
    wr(4'd8, 32'h0);
    @(posedge clk); #1;
    check("en0_blank", {22'h0, out_port}, {22'h0, all_off});
    wr(4'd8, 32'h1);
    @(posedge clk); #1;
    check("en1_digit0", {57'h0, out_port[6:0]}, 64'h36);
    check("en1_digit2", {57'h0, out_port[20:14]}, 64'h12);

    wr(4'd0, 32'h08);
    wr(4'd9, 32'h01);
    wr(4'd8, 32'h03);
    for (int k = 1; k <= 12; k++) begin
      @(posedge clk); #1;
      address = 4'd11; #1;
      check("blink_status", {63'h0, readdata[0]}, {63'h0, BLK & st_exp[k-1]});
      check("blink_pins", {57'h0, out_port[6:0]}, (BLK & of_exp[k-1]) ? 64'h7F : 64'h00);
    end

    repeat (6) @(posedge clk);
    wr(4'd8, 32'h03);
    address = 4'd11; #1;
    check("restart_at_wrap", {63'h0, readdata[0]}, 64'h0);
    for (int k = 1; k <= 5; k++) begin
      @(posedge clk); #2;
      check("after_restart", {63'h0, readdata[0]}, {63'h0, BLK && (k >= 4)});
    end

    wr(4'd7, 32'hFF);
    wr(4'd10, 32'hFFFF_FFFF);
    address = 4'd7;  #1 check("read_addr7", {32'h0, readdata}, 64'h0);
    address = 4'd10; #1 check("read_addr10", {32'h0, readdata}, 64'h0);
    address = 4'd9;  #1 check("read_blink", {32'h0, readdata}, BLK ? 64'h1 : 64'h0);

    @(posedge clk); #3 reset_n = 1'b0;
    #1 check("midrst_out_port", {22'h0, out_port}, {22'h0, all_off});
    address = 4'd11; #1 check("midrst_status", {32'h0, readdata}, 64'h0);
    address = 4'd9;  #1 check("midrst_blink", {32'h0, readdata}, 64'h0);
    address = 4'd0;  #1 check("midrst_digit0", {32'h0, readdata}, 64'h80);
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;
    repeat (10) @(posedge clk);
    #1 address = 4'd8;
    #1 check("post_rst_ctrl", {32'h0, readdata}, 64'h1);
    @(negedge clk);
    cmp_on = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
